// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_GRANT = S_GRANT,
        ST_GAP   = S_GAP
    } state_t;

endpackage

// File: rtl/onehot_dec_4x16.sv
// Active-high 4-to-16 decoder with enable; all outputs low when disabled.
// Latency: purely combinational. Backpressure: none.
module onehot_dec_4x16
    import rr_arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] a,
    output logic [N_REQ-1:0] d
);

    always_comb begin
        d = '0;
        if (en) begin
            d[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters, IDLE -> GRANT -> GAP FSM; RR_TIMEOUT_EN adds a hold limit.
// Latency: req seen at edge k gives grant after edge k. Backpressure: owner holds until req drops, rel, or timeout.
module rr_arbiter_16
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD > (2**HOLD_W) - 1) begin : g_cfg_err
        $error("rr_arbiter_16: MAX_HOLD out of range for HOLD_W");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_d;
    logic             vld_d;
    logic             scan_hit;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_end;
    logic             timeout;

    // First set request at or after ptr, wrapping modulo 16.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!scan_hit && req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

`ifdef RR_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state_q == ST_GRANT && !grant_end) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    assign timeout = (state_q == ST_GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    assign grant_end = (state_q == ST_GRANT) && (!req[gnt_idx] || rel || timeout);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = gnt_idx;
        vld_d   = gnt_valid;
        case (state_q)
            ST_IDLE: begin
                if (scan_hit) begin
                    state_d = ST_GRANT;
                    idx_d   = scan_idx;
                    vld_d   = 1'b1;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    state_d = ST_GAP;
                    ptr_d   = gnt_idx + IDX_W'(1);
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx   <= idx_d;
            gnt_valid <= vld_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

    onehot_dec_4x16 u_dec (
        .en (gnt_valid),
        .a  (gnt_idx),
        .d  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter_16;

    localparam int MAXH = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        busy;
    logic [21:0] obs;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: current owner (-1 = none), gap flag, priority start, cycles held beyond the first.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_gap   = 1'b0;

    rr_arbiter_16 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, gnt_idx, gnt_valid, busy};

    function automatic logic [21:0] exp_obs();
        logic [15:0] g;
        logic [3:0]  ix;
        g  = '0;
        ix = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            ix = 4'(m_owner);
        end
        return {g, ix, (m_owner >= 0), (m_owner >= 0) || m_gap};
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_gap   = 1'b0;
    endfunction

    function automatic void model_edge();
        if (m_owner >= 0) begin
            if (!req[m_owner] || rel || (TO_EN && m_hold == MAXH - 1)) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_gap   = 1'b1;
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                    m_hold  = 0;
                end
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        #2;
        n_chk++;
        if (obs !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_init: got %h want %h", obs, 22'h0);
        end
        rst = 1'b0;
        model_reset();
        tick();
        req = 16'h0020;
        tick();
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0020) begin
            n_fail++;
            $display("FAIL reset_owner5: got %h want %h", obs, exp_obs());
        end
        #3;
        rst = 1'b1;
        req = '0;
        #1;
        n_chk++;
        if ({gnt, gnt_valid, gnt_idx, busy} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_async: gnt=%h vld=%b idx=%0d busy=%b want all zero",
                     gnt, gnt_valid, gnt_idx, busy);
        end
        model_reset();
        #1;
        rst = 1'b0;
        req = 16'h0021;
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_ptr0: got %h want gnt 0001 obs %h", obs, exp_obs());
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        int   order[$];
        logic prev_vld;
        do_reset();
        prev_vld = 1'b0;
        for (int c = 0; c < 200 && order.size() < 17; c++) begin
            req = 16'hFFFF;
            if (m_owner >= 0 && m_hold >= 2) req[m_owner] = 1'b0;
            tick();
            n_chk++;
            if (obs !== exp_obs()) begin
                n_fail++;
                $display("FAIL rotation_cyc%0d: got %h want %h", c, obs, exp_obs());
            end
            if (gnt_valid && !prev_vld) order.push_back(int'(gnt_idx));
            prev_vld = gnt_valid;
        end
        n_chk++;
        if (order.size() != 17) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants want 17", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_chk++;
            if (order[i] != i % 16) begin
                n_fail++;
                $display("FAIL rotation_order[%0d]: got %0d want %0d", i, order[i], i % 16);
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] want [7];
        logic [15:0] stim [7];
        want = '{16'h2000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0008};
        stim = '{16'h2000, 16'h0000, 16'h0009, 16'h0009, 16'h0008, 16'h0008, 16'h0008};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req = stim[i];
            tick();
            n_chk++;
            if (obs !== exp_obs() || gnt !== want[i]) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got gnt %h obs %h want gnt %h obs %h",
                         i, gnt, obs, want[i], exp_obs());
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_simul();
        do_reset();
        req = 16'h0080;
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0080) begin
            n_fail++;
            $display("FAIL simul_grant: got gnt %h want 0080", gnt);
        end
        rel = 1'b1;
        req = '0;
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_gap: got gnt %h busy %b want 0000 1", gnt, busy);
        end
        req = 16'h0080;
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_idle: got gnt %h busy %b want 0000 0", gnt, busy);
        end
        rel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (obs !== exp_obs() || gnt !== 16'h0080) begin
                n_fail++;
                $display("FAIL simul_regrant%0d: got gnt %h want 0080", i, gnt);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

`ifdef RR_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] want [16];
        want = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h0, 16'h0, 16'h4, 16'h4,
                 16'h4, 16'h4, 16'h0, 16'h0, 16'h2, 16'h2, 16'h2, 16'h2};
        do_reset();
        req = 16'h0006;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_chk++;
            if (obs !== exp_obs() || gnt !== want[i]) begin
                n_fail++;
                $display("FAIL timeout_cyc%0d: got gnt %h want %h", i, gnt, want[i]);
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        req = 16'h0002;
        tick();
        for (int i = 0; i < 100; i++) begin
            n_chk++;
            if (gnt !== 16'h0002 || obs !== exp_obs()) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: got gnt %h want 0002", i, gnt);
            end
            tick();
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got gnt %h busy %b want 0000 1", gnt, busy);
        end
        tick();
        tick();
        n_chk++;
        if (obs !== exp_obs() || gnt !== 16'h0002) begin
            n_fail++;
            $display("FAIL hold_regrant: got gnt %h want 0002", gnt);
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
            end
            rel = ($urandom_range(0, 9) == 0);
            tick();
            n_chk++;
            if (obs !== exp_obs() || !$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h want %h (req %h)", c, obs, exp_obs(), req);
            end
        end
        req = '0;
        rel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_simul();
`ifdef RR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
